// File: rtl/core_ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory handshakes,
// write-enable pulses, sign-extender mode select, timeout trap and retire counter.
module core_ctrl_fsm #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  ir_we,
  output logic                  alu_en,
  output logic                  reg_we,
  output logic                  pc_we,
  output logic [2:0]            sx_op,
  output logic                  trap,
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] instret
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd5;

  localparam logic [2:0] SX_3100 = 3'd0;
  localparam logic [2:0] SX_1100 = 3'd1;

  localparam logic [1:0] C_ALU = 2'd0;
  localparam logic [1:0] C_LD  = 2'd1;
  localparam logic [1:0] C_ST  = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  r_hold;
  logic [1:0]            r_class;
  logic [2:0]            r_sx;
  logic [CW-1:0]         r_wait;
  logic [DATA_WIDTH-1:0] r_instret;

  logic                  w_imem_req;
  logic                  w_dmem_req;
  logic                  w_imem_done;
  logic                  w_dmem_done;
  logic                  w_waiting;
  logic                  w_timeout;
  logic                  w_pc_we;
  logic                  w_dec_valid;
  logic [1:0]            w_dec_class;
  logic [2:0]            w_dec_sx;
  logic                  w_unused;

  assign w_unused = ^instr[DATA_WIDTH-1:7];

  // r_hold keeps requests low for the first cycle after reset even though state is FETCH
  assign w_imem_req  = !r_hold && (r_state == S_FETCH);
  assign w_dmem_req  = !r_hold && (r_state == S_MEM);
  assign w_imem_done = w_imem_req && imem_ack;
  assign w_dmem_done = w_dmem_req && dmem_ack;
  assign w_waiting   = (w_imem_req && !imem_ack) || (w_dmem_req && !dmem_ack);
  assign w_timeout   = (r_wait == CW'(MEM_TIMEOUT));
  assign w_pc_we     = (r_state == S_WB) || (w_dmem_done && (r_class == C_ST));

  always_comb begin
    w_dec_valid = 1'b1;
    w_dec_class = C_ALU;
    w_dec_sx    = SX_1100;
    case (instr[6:0])
      OPC_OP:     w_dec_sx    = SX_3100;
      OPC_OP_IMM: w_dec_class = C_ALU;
      OPC_LOAD:   w_dec_class = C_LD;
      OPC_STORE:  w_dec_class = C_ST;
      default:    w_dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_imem_done)                 w_next = S_DECODE;
        else if (w_imem_req && w_timeout) w_next = S_TRAP;
      end
      S_DECODE:  w_next = w_dec_valid ? S_EXECUTE : S_TRAP;
      S_EXECUTE: w_next = (r_class == C_ALU) ? S_WB : S_MEM;
      S_MEM: begin
        if (w_dmem_done)   w_next = (r_class == C_LD) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_WB:      w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_hold    <= 1'b1;
      r_class   <= C_ALU;
      r_sx      <= SX_3100;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= 1'b0;
      if ((r_state == S_DECODE) && w_dec_valid) begin
        r_class <= w_dec_class;
        r_sx    <= w_dec_sx;
      end
      // Counter restarts on entry to a waiting state and saturates once the limit is hit
      if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM)))
        r_wait <= '0;
      else if (w_waiting && !w_timeout)
        r_wait <= r_wait + CW'(1);
      if (w_pc_we)
        r_instret <= r_instret + DATA_WIDTH'(1);
    end
  end

  assign imem_req = w_imem_req;
  assign dmem_req = w_dmem_req;
  assign dmem_we  = w_dmem_req && (r_class == C_ST);
  assign ir_we    = w_imem_done;
  assign alu_en   = (r_state == S_EXECUTE);
  assign reg_we   = (r_state == S_WB);
  assign pc_we    = w_pc_we;
  assign sx_op    = r_sx;
  assign trap     = (r_state == S_TRAP);
  assign state    = r_state;
  assign instret  = r_instret;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: directed vector table, hand sequences for timeout/trap/reset,
// randomized instruction stream checked against a per-instruction cycle schedule, and counter wrap.
module tb_core_ctrl_fsm;

  localparam logic [7:0] O_IREQ = 8'h80;
  localparam logic [7:0] O_DREQ = 8'h40;
  localparam logic [7:0] O_DWE  = 8'h20;
  localparam logic [7:0] O_IRWE = 8'h10;
  localparam logic [7:0] O_ALU  = 8'h08;
  localparam logic [7:0] O_REG  = 8'h04;
  localparam logic [7:0] O_PC   = 8'h02;
  localparam logic [7:0] O_TRAP = 8'h01;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] ILL  = 32'h0000007F;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        ia;
    logic        da;
    logic        chk;
    logic [7:0]  out;
    logic [2:0]  st;
    logic [2:0]  sx;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ack, dmem_ack;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, ir_we, alu_en, reg_we, pc_we, trap;
  logic [2:0]  sx_op, state;
  logic [31:0] instret;
  logic [7:0]  o_vec;

  logic        wrst;
  logic [7:0]  winstr;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_alu_en, w_reg_we, w_pc_we, w_trap;
  logic [2:0]  w_sx_op, w_state;
  logic [7:0]  w_instret;

  int checks = 0;
  int errors = 0;

  assign o_vec = {imem_req, dmem_req, dmem_we, ir_we, alu_en, reg_we, pc_we, trap};

  core_ctrl_fsm #(.DATA_WIDTH(32), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .alu_en(alu_en), .reg_we(reg_we), .pc_we(pc_we), .sx_op(sx_op), .trap(trap),
    .state(state), .instret(instret)
  );

  core_ctrl_fsm #(.DATA_WIDTH(8), .MEM_TIMEOUT(255)) u_wrap (
    .clk(clk), .rst(wrst), .instr(winstr), .imem_ack(1'b1), .dmem_ack(1'b0),
    .imem_req(w_imem_req), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .ir_we(w_ir_we),
    .alu_en(w_alu_en), .reg_we(w_reg_we), .pc_we(w_pc_we), .sx_op(w_sx_op), .trap(w_trap),
    .state(w_state), .instret(w_instret)
  );

  function automatic vec_t mk(input logic r, input logic [31:0] i, input logic ia, input logic da,
                              input logic c, input logic [7:0] o, input logic [2:0] st,
                              input logic [2:0] sx, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.instr = i; v.ia = ia; v.da = da; v.chk = c;
    v.out = o; v.st = st; v.sx = sx; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input string nm, input int idx, input vec_t v);
    rst = v.rst; instr = v.instr; imem_ack = v.ia; dmem_ack = v.da;
    @(negedge clk);
    if (v.chk) begin
      check({nm, "_outs"},    idx, {24'd0, o_vec},   {24'd0, v.out});
      check({nm, "_state"},   idx, {29'd0, state},   {29'd0, v.st});
      check({nm, "_sx_op"},   idx, {29'd0, sx_op},   {29'd0, v.sx});
      check({nm, "_instret"}, idx, instret,          v.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        rq[$];
    vec_t        hs[$];
    int unsigned cnt;
    logic [2:0]  msx;
    int unsigned kind, df, dm, wcnt;
    logic [6:0]  opc;
    logic [31:0] rnd, ins;
    logic        is_st;

    rst = 1'b1; instr = ADDI; imem_ack = 1'b0; dmem_ack = 1'b0;
    wrst = 1'b1; winstr = 8'h13;

    // rst, instr, ia, da, chk, outs, state, sx_op, instret
    tbl.push_back(mk(1, ADDI, 0, 0, 0, 8'h00, 3'd0, 3'd0, 0));
    tbl.push_back(mk(1, ADDI, 0, 0, 1, 8'h00, 3'd0, 3'd0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 1, 8'h00, 3'd0, 3'd0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 1, O_IREQ | O_IRWE, 3'd0, 3'd0, 0));
    tbl.push_back(mk(0, ADDI, 0, 1, 1, 8'h00, 3'd1, 3'd0, 0));
    tbl.push_back(mk(0, ADDI, 0, 0, 1, O_ALU, 3'd2, 3'd1, 0));
    tbl.push_back(mk(0, ADDI, 0, 0, 1, O_REG | O_PC, 3'd4, 3'd1, 0));
    tbl.push_back(mk(0, SW,   0, 0, 1, O_IREQ, 3'd0, 3'd1, 1));
    tbl.push_back(mk(0, SW,   1, 1, 1, O_IREQ | O_IRWE, 3'd0, 3'd1, 1));
    tbl.push_back(mk(0, SW,   0, 0, 1, 8'h00, 3'd1, 3'd1, 1));
    tbl.push_back(mk(0, SW,   0, 0, 1, O_ALU, 3'd2, 3'd1, 1));
    tbl.push_back(mk(0, SW,   1, 0, 1, O_DREQ | O_DWE, 3'd3, 3'd1, 1));
    tbl.push_back(mk(0, SW,   1, 1, 1, O_DREQ | O_DWE | O_PC, 3'd3, 3'd1, 1));
    tbl.push_back(mk(0, ADD,  1, 0, 1, O_IREQ | O_IRWE, 3'd0, 3'd1, 2));
    tbl.push_back(mk(0, ADD,  0, 0, 1, 8'h00, 3'd1, 3'd1, 2));
    tbl.push_back(mk(0, ADD,  0, 0, 1, O_ALU, 3'd2, 3'd0, 2));
    tbl.push_back(mk(0, ADD,  0, 0, 1, O_REG | O_PC, 3'd4, 3'd0, 2));
    tbl.push_back(mk(0, ADD,  0, 0, 1, O_IREQ, 3'd0, 3'd0, 3));
    foreach (tbl[i]) run_vec("table", i, tbl[i]);

    // load with data ack delayed three cycles
    hs.push_back(mk(0, LW, 1, 0, 1, O_IREQ | O_IRWE, 3'd0, 3'd0, 3));
    hs.push_back(mk(0, LW, 0, 0, 1, 8'h00, 3'd1, 3'd0, 3));
    hs.push_back(mk(0, LW, 0, 0, 1, O_ALU, 3'd2, 3'd1, 3));
    for (int k = 0; k < 3; k++) hs.push_back(mk(0, LW, 1, 0, 1, O_DREQ, 3'd3, 3'd1, 3));
    hs.push_back(mk(0, LW, 0, 1, 1, O_DREQ, 3'd3, 3'd1, 3));
    hs.push_back(mk(0, LW, 0, 0, 1, O_REG | O_PC, 3'd4, 3'd1, 3));
    hs.push_back(mk(0, LW, 0, 0, 1, O_IREQ, 3'd0, 3'd1, 4));
    // illegal opcode traps, sticky until reset
    hs.push_back(mk(0, ILL, 1, 0, 1, O_IREQ | O_IRWE, 3'd0, 3'd1, 4));
    hs.push_back(mk(0, ILL, 0, 0, 1, 8'h00, 3'd1, 3'd1, 4));
    for (int k = 0; k < 4; k++) hs.push_back(mk(0, ILL, rb(), rb(), 1, O_TRAP, 3'd5, 3'd1, 4));
    hs.push_back(mk(1, ILL, 0, 0, 0, 8'h00, 3'd0, 3'd0, 0));
    hs.push_back(mk(0, ILL, 0, 0, 1, 8'h00, 3'd0, 3'd0, 0));
    // fetch timeout (limit 4): five unacked request cycles then trap
    for (int k = 0; k < 5; k++) hs.push_back(mk(0, ADDI, 0, 1, 1, O_IREQ, 3'd0, 3'd0, 0));
    hs.push_back(mk(0, ADDI, 0, 0, 1, O_TRAP, 3'd5, 3'd0, 0));
    hs.push_back(mk(1, ADDI, 0, 0, 0, 8'h00, 3'd0, 3'd0, 0));
    hs.push_back(mk(0, ADDI, 0, 0, 1, 8'h00, 3'd0, 3'd0, 0));
    // ack arriving on the timeout cycle wins
    for (int k = 0; k < 4; k++) hs.push_back(mk(0, ADDI, 0, 0, 1, O_IREQ, 3'd0, 3'd0, 0));
    hs.push_back(mk(0, ADDI, 1, 0, 1, O_IREQ | O_IRWE, 3'd0, 3'd0, 0));
    hs.push_back(mk(0, ADDI, 0, 0, 1, 8'h00, 3'd1, 3'd0, 0));
    hs.push_back(mk(0, ADDI, 0, 0, 1, O_ALU, 3'd2, 3'd1, 0));
    hs.push_back(mk(0, ADDI, 0, 0, 1, O_REG | O_PC, 3'd4, 3'd1, 0));
    // reset mid data handshake
    hs.push_back(mk(0, LW, 1, 0, 1, O_IREQ | O_IRWE, 3'd0, 3'd1, 1));
    hs.push_back(mk(0, LW, 0, 0, 1, 8'h00, 3'd1, 3'd1, 1));
    hs.push_back(mk(0, LW, 0, 0, 1, O_ALU, 3'd2, 3'd1, 1));
    hs.push_back(mk(0, LW, 0, 0, 1, O_DREQ, 3'd3, 3'd1, 1));
    hs.push_back(mk(1, LW, 0, 1, 0, 8'h00, 3'd0, 3'd0, 0));
    hs.push_back(mk(0, LW, 0, 1, 1, 8'h00, 3'd0, 3'd0, 0));
    foreach (hs[i]) run_vec("seq", i, hs[i]);

    // Random stream: each instruction expands into its expected cycle schedule
    cnt = 0;
    msx = 3'd0;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rnd  = $urandom();
      case (kind)
        0, 1, 2: opc = 7'b0110011;
        3, 4:    opc = 7'b0010011;
        5, 6:    opc = 7'b0000011;
        7, 8:    opc = 7'b0100011;
        default: opc = rb() ? 7'h63 : 7'h7F;
      endcase
      ins   = {rnd[31:7], opc};
      is_st = (kind == 7) || (kind == 8);
      df    = $urandom_range(0, 3);
      for (int k = 0; k < int'(df); k++) rq.push_back(mk(0, ins, 0, rb(), 1, O_IREQ, 3'd0, msx, cnt));
      rq.push_back(mk(0, ins, 1, rb(), 1, O_IREQ | O_IRWE, 3'd0, msx, cnt));
      rq.push_back(mk(0, ins, rb(), rb(), 1, 8'h00, 3'd1, msx, cnt));
      if (kind == 9) begin
        rq.push_back(mk(0, ins, rb(), rb(), 1, O_TRAP, 3'd5, msx, cnt));
        rq.push_back(mk(0, ins, rb(), rb(), 1, O_TRAP, 3'd5, msx, cnt));
        rq.push_back(mk(1, ins, 0, 0, 0, 8'h00, 3'd0, 3'd0, 0));
        rq.push_back(mk(0, ins, rb(), rb(), 1, 8'h00, 3'd0, 3'd0, 0));
        msx = 3'd0;
        cnt = 0;
      end else begin
        msx = (kind <= 2) ? 3'd0 : 3'd1;
        rq.push_back(mk(0, ins, rb(), rb(), 1, O_ALU, 3'd2, msx, cnt));
        if (kind <= 4) begin
          rq.push_back(mk(0, ins, rb(), rb(), 1, O_REG | O_PC, 3'd4, msx, cnt));
          cnt++;
        end else begin
          dm = $urandom_range(0, 3);
          for (int k = 0; k < int'(dm); k++)
            rq.push_back(mk(0, ins, rb(), 0, 1, O_DREQ | (is_st ? O_DWE : 8'h00), 3'd3, msx, cnt));
          rq.push_back(mk(0, ins, rb(), 1, 1,
                          O_DREQ | (is_st ? (O_DWE | O_PC) : 8'h00), 3'd3, msx, cnt));
          if (!is_st)
            rq.push_back(mk(0, ins, rb(), rb(), 1, O_REG | O_PC, 3'd4, msx, cnt));
          cnt++;
        end
      end
    end
    foreach (rq[i]) run_vec("rand", i, rq[i]);

    // 8-bit instance: retire continuously past 255 and watch the counter wrap to 0
    @(negedge clk);
    @(posedge clk);
    #1 wrst = 1'b0;
    wcnt = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (w_pc_we) begin
        check("wrap_instret", c, {24'd0, w_instret}, wcnt % 256);
        wcnt++;
      end
    end
    check("wrap_reached", 0, {31'd0, wcnt >= 257}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
